uart_brg_mc: RTL



---
 rtl/uart_brg_mc.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_brg_mc.sv
// uart_brg_mc: multi-channel fractional-N baud rate generator.
// A single adder is time-shared across NCHAN phase accumulators, one slot
// per clk in round-robin order. The carry out of a channel's add becomes its
// one-cycle 16x-oversample clock-enable.

// One channel: holds the phase accumulator and the registered carry.
module uart_brg_lane #(
  parameter int ACCW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,     // this channel owns the current slot
  input  logic            en,
  input  logic            resync,
  input  logic [ACCW:0]   sum,     // shared adder result, meaningful when sel
  output logic [ACCW-1:0] acc,
  output logic            pulse
);
  // Accumulator update; a resync overrides the slot update and suppresses its carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (en && resync) begin
        acc <= {1'b1, {(ACCW-1){1'b0}}};
      end else if (sel) begin
        if (!en) begin
          acc <= '0;
        end else begin
          acc   <= sum[ACCW-1:0];
          pulse <= sum[ACCW];
        end
      end
    end
  end
endmodule

module uart_brg_mc #(
  parameter int NCHAN  = 8,
  parameter int ACCW   = 32,
  parameter int CLKFRQ = 50000000,
  parameter int CLKDIV = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*NCHAN-1:0] speed,
  input  logic [NCHAN-1:0]   chanEN,
  input  logic [NCHAN-1:0]   resync,
  input  logic               tblWR,
  input  logic [3:0]         tblADDR,
  input  logic [ACCW-1:0]    tblDATA,
  output logic [NCHAN-1:0]   brgCLKEN
);
  localparam int SW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  // Standard rates in tenths of a baud so 134.5 stays integral.
  function automatic longint unsigned rate_x10(input int i);
    case (i)
      0:       return 64'd500;
      1:       return 64'd750;
      2:       return 64'd1100;
      3:       return 64'd1345;
      4:       return 64'd1500;
      5:       return 64'd3000;
      6:       return 64'd6000;
      7:       return 64'd12000;
      8:       return 64'd18000;
      9:       return 64'd20000;
      10:      return 64'd24000;
      11:      return 64'd36000;
      12:      return 64'd48000;
      13:      return 64'd72000;
      14:      return 64'd96000;
      default: return 64'd1152000;
    endcase
  endfunction

  // Rounded increment per rate, saturated to the accumulator width.
  function automatic logic [15:0][ACCW-1:0] dflt_tbl();
    logic [15:0][ACCW-1:0] t;
    longint unsigned num, den, q, mx;
    mx  = (64'd1 << ACCW) - 64'd1;
    den = 64'(CLKFRQ) * 64'd10;
    for (int i = 0; i < 16; i++) begin
      num  = (64'd1 << ACCW) * 64'(CLKDIV) * 64'(NCHAN) * rate_x10(i);
      q    = (num + den / 64'd2) / den;
      t[i] = (q > mx) ? mx[ACCW-1:0] : q[ACCW-1:0];
    end
    return t;
  endfunction

  localparam logic [15:0][ACCW-1:0] DFLT = dflt_tbl();

  logic [SW-1:0]               slot;
  logic [15:0][ACCW-1:0]       tbl;
  logic [NCHAN-1:0][ACCW-1:0]  acc;
  logic [NCHAN-1:0][3:0]       spd;
  logic [NCHAN-1:0]            pulse;
  logic [ACCW:0]               sum;

  assign spd = speed;

  // Shared adder: current slot's accumulator plus its selected increment.
  assign sum = {1'b0, acc[slot]} + {1'b0, tbl[spd[slot]]};

  // Round-robin slot counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         slot <= '0;
    else if (slot == SW'(NCHAN - 1)) slot <= '0;
    else                             slot <= slot + 1'b1;
  end

  // Increment table; the adder sees the old entry on the write edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        tbl <= DFLT;
    else if (tblWR) tbl[tblADDR] <= tblDATA;
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_lane
    uart_brg_lane #(.ACCW(ACCW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .sel    (slot == SW'(k)),
      .en     (chanEN[k]),
      .resync (resync[k]),
      .sum    (sum),
      .acc    (acc[k]),
      .pulse  (pulse[k])
    );
  end

  assign brgCLKEN = pulse;
endmodule
